// File: rtl/hiscore_uploader.sv
// Hiscore read-back path: loads the region table from the config download, then
// pauses the CPU and streams the configured RAM regions to the HPS one byte per ioctl_rd.
module hiscore_uploader #(
   parameter int unsigned HS_ADDRESSWIDTH = 16,
   parameter int unsigned CFG_ENTRIES     = 4,
   parameter int unsigned RAM_LATENCY     = 2,
   parameter logic [7:0]  CFG_INDEX       = 8'd3,
   parameter logic [7:0]  DATA_INDEX      = 8'd4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ioctl_download,
   input  logic                       ioctl_upload,
   input  logic                       ioctl_wr,
   input  logic                       ioctl_rd,
   input  logic [7:0]                 ioctl_index,
   input  logic [24:0]                ioctl_addr,
   input  logic [7:0]                 ioctl_dout,
   output logic [7:0]                 ioctl_din,
   output logic                       ioctl_upload_req,
   input  logic                       osd_status,
   input  logic                       autosave,
   input  logic                       paused,
   output logic                       pause_cpu,
   output logic [HS_ADDRESSWIDTH-1:0] ram_address,
   input  logic [7:0]                 data_from_ram,
   output logic                       ram_read,
   output logic                       configured
);

   localparam int unsigned EW  = (CFG_ENTRIES > 1) ? $clog2(CFG_ENTRIES) : 1;
   localparam int unsigned ECW = EW + 1;
   localparam int unsigned BCW = EW + 9;
   localparam int unsigned LCW = 3;

   typedef struct packed {
      logic [15:0] start;
      logic [7:0]  len_m1;
   } cfg_entry_t;

   typedef enum logic [2:0] {
      IDLE,
      PAUSE_WAIT,
      READY,
      READ,
      HOLD
   } state_t;

   cfg_entry_t     cfg_tbl [CFG_ENTRIES];
   logic [ECW-1:0] entry_count;
   logic           cfg_dl;
   logic           dl_d;
   logic           ul_d;
   logic           osd_d;

   state_t         state;
   logic [ECW-1:0] entry;
   logic [7:0]     offset;
   logic [BCW-1:0] byte_count;
   logic [LCW-1:0] lat_cnt;
   logic           pending;

   logic [22:0]    cfg_e;
   logic           cfg_wr;
   logic           cfg_hit;
   logic           cfg_start;
   logic           dl_fall;
   logic           ul_rise;
   logic           osd_fall;
   logic [ECW-1:0] ec_base;
   logic [ECW-1:0] ec_next;
   cfg_entry_t     cur;
   logic           cursor_valid;
   logic           addr_hit;
   logic           rd_req;

   assign cfg_e     = ioctl_addr[24:2];
   assign cfg_wr    = ioctl_wr && ioctl_download && (ioctl_index == CFG_INDEX);
   assign cfg_hit   = cfg_wr && (cfg_e < 23'(CFG_ENTRIES));
   assign cfg_start = ioctl_download && !dl_d && (ioctl_index == CFG_INDEX);
   assign dl_fall   = dl_d && !ioctl_download;
   assign ul_rise   = ioctl_upload && !ul_d;
   assign osd_fall  = osd_d && !osd_status;

   // A fresh config download restarts the entry count; the count tracks the highest entry written.
   assign ec_base = cfg_start ? '0 : entry_count;
   assign ec_next = (cfg_hit && (ECW'(cfg_e) >= ec_base)) ? ECW'(cfg_e) + ECW'(1) : ec_base;

   assign cur          = cfg_tbl[entry[EW-1:0]];
   assign cursor_valid = entry < entry_count;
   assign addr_hit     = ioctl_addr == 25'(byte_count);
   assign rd_req       = ioctl_rd || pending;

   // Config table load and the configured flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < CFG_ENTRIES; i++) begin
            cfg_tbl[i] <= '0;
         end
         entry_count <= '0;
         configured  <= 1'b0;
         cfg_dl      <= 1'b0;
         dl_d        <= 1'b0;
      end else begin
         dl_d        <= ioctl_download;
         entry_count <= ec_next;
         if (cfg_start) begin
            cfg_dl     <= 1'b1;
            configured <= 1'b0;
         end else if (dl_fall && cfg_dl) begin
            cfg_dl     <= 1'b0;
            configured <= (entry_count != '0);
         end
         if (cfg_hit) begin
            case (ioctl_addr[1:0])
               2'd0:    cfg_tbl[cfg_e[EW-1:0]].start[15:8] <= ioctl_dout;
               2'd1:    cfg_tbl[cfg_e[EW-1:0]].start[7:0]  <= ioctl_dout;
               2'd2:    cfg_tbl[cfg_e[EW-1:0]].len_m1      <= ioctl_dout;
               default: ;
            endcase
         end
      end
   end

   // Upload sequencer: pause handshake, in-order byte reads, autosave request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         pause_cpu        <= 1'b0;
         ram_read         <= 1'b0;
         ram_address      <= '0;
         ioctl_din        <= '0;
         ioctl_upload_req <= 1'b0;
         entry            <= '0;
         offset           <= '0;
         byte_count       <= '0;
         lat_cnt          <= '0;
         pending          <= 1'b0;
         ul_d             <= 1'b0;
         osd_d            <= 1'b0;
      end else begin
         ul_d             <= ioctl_upload;
         osd_d            <= osd_status;
         ioctl_upload_req <= osd_fall && autosave && configured && (state == IDLE);

         if ((state != IDLE) && !ioctl_upload) begin
            state     <= IDLE;
            ram_read  <= 1'b0;
            pause_cpu <= 1'b0;
            pending   <= 1'b0;
         end else begin
            // Strobes that cannot be serviced this cycle are remembered.
            if ((state != IDLE) && ioctl_rd) begin
               pending <= 1'b1;
            end
            case (state)
               IDLE: begin
                  if (ul_rise && (ioctl_index == DATA_INDEX) && configured) begin
                     entry      <= '0;
                     offset     <= '0;
                     byte_count <= '0;
                     pending    <= 1'b0;
                     pause_cpu  <= 1'b1;
                     state      <= PAUSE_WAIT;
                  end
               end
               PAUSE_WAIT, READY: begin
                  if (paused) begin
                     state <= READY;
                     if (rd_req) begin
                        pending <= 1'b0;
                        if (addr_hit && cursor_valid) begin
                           ram_address <= HS_ADDRESSWIDTH'(cur.start) + HS_ADDRESSWIDTH'(offset);
                           ram_read    <= 1'b1;
                           lat_cnt     <= '0;
                           state       <= READ;
                        end else begin
                           ioctl_din <= 8'h00;
                        end
                     end
                  end
               end
               READ: begin
                  if (paused) begin
                     if (lat_cnt == LCW'(RAM_LATENCY)) begin
                        ioctl_din  <= data_from_ram;
                        ram_read   <= 1'b0;
                        byte_count <= byte_count + BCW'(1);
                        if (offset == cur.len_m1) begin
                           entry  <= entry + ECW'(1);
                           offset <= '0;
                        end else begin
                           offset <= offset + 8'd1;
                        end
                        state <= HOLD;
                     end else begin
                        lat_cnt <= lat_cnt + LCW'(1);
                     end
                  end
               end
               HOLD: begin
                  if (paused) begin
                     state <= READY;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hiscore_uploader.sv
// Bench for hiscore_uploader: behavioural RAM with fixed latency, region model and
// a queue of expected upload bytes.
`timescale 1ns/1ps
module tb_hiscore_uploader;

   localparam int L = 2;

   logic        clk;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_upload;
   logic        ioctl_wr;
   logic        ioctl_rd;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_din;
   logic        ioctl_upload_req;
   logic        osd_status;
   logic        autosave;
   logic        paused;
   logic        pause_cpu;
   logic [15:0] ram_address;
   logic [7:0]  data_from_ram;
   logic        ram_read;
   logic        configured;

   int          n_cmp;
   int          n_bad;
   logic [15:0] rs [4];
   int          rl [4];
   int          nreg;
   int          bc;
   logic [7:0]  sb [$];
   logic [7:0]  pipe [L];

   hiscore_uploader #(
      .HS_ADDRESSWIDTH(16),
      .CFG_ENTRIES    (4),
      .RAM_LATENCY    (L),
      .CFG_INDEX      (8'd3),
      .DATA_INDEX     (8'd4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ioctl_download  (ioctl_download),
      .ioctl_upload    (ioctl_upload),
      .ioctl_wr        (ioctl_wr),
      .ioctl_rd        (ioctl_rd),
      .ioctl_index     (ioctl_index),
      .ioctl_addr      (ioctl_addr),
      .ioctl_dout      (ioctl_dout),
      .ioctl_din       (ioctl_din),
      .ioctl_upload_req(ioctl_upload_req),
      .osd_status      (osd_status),
      .autosave        (autosave),
      .paused          (paused),
      .pause_cpu       (pause_cpu),
      .ram_address     (ram_address),
      .data_from_ram   (data_from_ram),
      .ram_read        (ram_read),
      .configured      (configured)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ram_val(input logic [15:0] a);
      logic [15:0] t;
      t = (a * 16'd37) ^ (a >> 7) ^ 16'h005A;
      return t[7:0];
   endfunction

   // RAM delivering data L clocks after the address is presented.
   always @(posedge clk) begin
      pipe[0] <= ram_val(ram_address);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign data_from_ram = pipe[L-1];

   function automatic int total_bytes();
      int t;
      t = 0;
      for (int r = 0; r < nreg; r++) t += rl[r];
      return t;
   endfunction

   function automatic logic [7:0] model_byte(input int idx);
      int k;
      k = idx;
      for (int r = 0; r < nreg; r++) begin
         if (k < rl[r]) return ram_val(rs[r] + 16'(k));
         k -= rl[r];
      end
      return 8'h00;
   endfunction

   // Strobe one read, queue its expected byte, return at the sample point (L+1 clocks later).
   task automatic do_rd(input int addr);
      logic [7:0] e;
      if ((addr == bc) && (bc < total_bytes())) begin
         e = model_byte(bc);
         bc++;
      end else begin
         e = 8'h00;
      end
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      ioctl_addr = 25'(addr);
      ioctl_rd   = 1'b1;
      @(negedge clk);
      ioctl_rd   = 1'b0;
      repeat (L + 1) @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [7:0] idx, input bit stray);
      logic [7:0] b [4];
      @(negedge clk);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      for (int r = 0; r < nreg; r++) begin
         b[0] = rs[r][15:8];
         b[1] = rs[r][7:0];
         b[2] = 8'(rl[r] - 1);
         b[3] = 8'hA5;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ioctl_addr = 25'(r * 4 + k);
            ioctl_dout = b[k];
            ioctl_wr   = 1'b1;
         end
      end
      if (stray) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ioctl_addr = 25'(16 + k);
            ioctl_dout = 8'h12;
            ioctl_wr   = 1'b1;
         end
      end
      @(negedge clk);
      ioctl_wr = 1'b0;
      @(negedge clk);
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic upload_start();
      @(negedge clk);
      ioctl_index  = 8'd4;
      ioctl_upload = 1'b1;
      bc = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic upload_end();
      @(negedge clk);
      ioctl_upload = 1'b0;
      repeat (2) @(negedge clk);
      paused = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_cmp++; if (ioctl_din !== 8'h00) begin n_bad++; $display("FAIL reset ioctl_din: got %02h expected 00", ioctl_din); end
      n_cmp++; if (ioctl_upload_req !== 1'b0) begin n_bad++; $display("FAIL reset upload_req: got %b expected 0", ioctl_upload_req); end
      n_cmp++; if (pause_cpu !== 1'b0) begin n_bad++; $display("FAIL reset pause_cpu: got %b expected 0", pause_cpu); end
      n_cmp++; if (ram_address !== 16'h0000) begin n_bad++; $display("FAIL reset ram_address: got %04h expected 0000", ram_address); end
      n_cmp++; if (ram_read !== 1'b0) begin n_bad++; $display("FAIL reset ram_read: got %b expected 0", ram_read); end
      n_cmp++; if (configured !== 1'b0) begin n_bad++; $display("FAIL reset configured: got %b expected 0", configured); end
   endtask

   task automatic test_unconfigured();
      logic [7:0] got, exp;
      nreg  = 1;
      rs[0] = 16'h1234;
      rl[0] = 4;
      load_cfg(8'd5, 1'b0);
      nreg  = 0;
      n_cmp++; if (configured !== 1'b0) begin n_bad++; $display("FAIL other_index configured: got %b expected 0", configured); end
      paused = 1'b1;
      upload_start();
      n_cmp++; if (pause_cpu !== 1'b0) begin n_bad++; $display("FAIL unconfigured pause_cpu: got %b expected 0", pause_cpu); end
      do_rd(0);
      got = ioctl_din;
      exp = sb.pop_front();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL unconfigured din: got %02h expected %02h", got, exp); end
      n_cmp++; if (ram_read !== 1'b0) begin n_bad++; $display("FAIL unconfigured ram_read: got %b expected 0", ram_read); end
      upload_end();
   endtask

   task automatic test_config_read();
      logic [7:0] got, exp;
      nreg  = 2;
      rs[0] = 16'hC000; rl[0] = 4;
      rs[1] = 16'hD110; rl[1] = 2;
      load_cfg(8'd3, 1'b1);
      n_cmp++; if (configured !== 1'b1) begin n_bad++; $display("FAIL cfg configured: got %b expected 1", configured); end
      paused = 1'b1;
      upload_start();
      n_cmp++; if (pause_cpu !== 1'b1) begin n_bad++; $display("FAIL upload pause_cpu: got %b expected 1", pause_cpu); end
      for (int a = 0; a <= 6; a++) begin
         do_rd(a);
         got = ioctl_din;
         exp = sb.pop_front();
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL seq rd addr %0d: got %02h expected %02h", a, got, exp); end
      end
      upload_end();
      n_cmp++; if (pause_cpu !== 1'b0) begin n_bad++; $display("FAIL upload_end pause_cpu: got %b expected 0", pause_cpu); end
   endtask

   task automatic test_pause_wait();
      logic [7:0] got, exp;
      bit rr;
      rr = 1'b0;
      paused = 1'b0;
      upload_start();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ioctl_addr = 25'd0;
         ioctl_rd   = (i == 5);
         @(posedge clk);
         #1;
         if (ram_read) rr = 1'b1;
      end
      @(negedge clk);
      ioctl_rd = 1'b0;
      n_cmp++; if (rr !== 1'b0) begin n_bad++; $display("FAIL pause_wait ram_read seen: got %b expected 0", rr); end
      n_cmp++; if (pause_cpu !== 1'b1) begin n_bad++; $display("FAIL pause_wait pause_cpu: got %b expected 1", pause_cpu); end
      sb.push_back(model_byte(0));
      bc = 1;
      @(negedge clk);
      paused = 1'b1;
      repeat (L + 2) @(posedge clk);
      #1;
      got = ioctl_din;
      exp = sb.pop_front();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL pending rd latency: got %02h expected %02h", got, exp); end
   endtask

   task automatic test_addr_mismatch();
      logic [7:0] got, exp;
      int addrs [3];
      addrs[0] = 1; addrs[1] = 5; addrs[2] = 2;
      for (int i = 0; i < 3; i++) begin
         do_rd(addrs[i]);
         got = ioctl_din;
         exp = sb.pop_front();
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mismatch rd addr %0d: got %02h expected %02h", addrs[i], got, exp); end
      end
      upload_end();
   endtask

   task automatic test_wrap();
      logic [7:0] got, exp;
      nreg  = 1;
      rs[0] = 16'hFFFF;
      rl[0] = 2;
      load_cfg(8'd3, 1'b0);
      n_cmp++; if (configured !== 1'b1) begin n_bad++; $display("FAIL wrap configured: got %b expected 1", configured); end
      paused = 1'b1;
      upload_start();
      for (int a = 0; a <= 2; a++) begin
         do_rd(a);
         got = ioctl_din;
         exp = sb.pop_front();
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL wrap rd addr %0d: got %02h expected %02h", a, got, exp); end
      end
      upload_end();
   endtask

   task automatic test_autosave();
      int cnt;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         autosave   = (pass == 0);
         osd_status = 1'b1;
         repeat (3) @(negedge clk);
         osd_status = 1'b0;
         cnt = 0;
         repeat (8) begin
            @(posedge clk);
            #1;
            if (ioctl_upload_req) cnt++;
         end
         n_cmp++; if (cnt !== ((pass == 0) ? 1 : 0)) begin n_bad++; $display("FAIL autosave=%0d req pulses: got %0d expected %0d", (pass == 0), cnt, (pass == 0) ? 1 : 0); end
      end
      autosave = 1'b0;
   endtask

   task automatic test_upload_abort();
      logic [7:0] got, exp;
      paused = 1'b1;
      upload_start();
      @(negedge clk);
      ioctl_addr = 25'd0;
      ioctl_rd   = 1'b1;
      @(negedge clk);
      ioctl_rd   = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (ram_read !== 1'b1) begin n_bad++; $display("FAIL abort ram_read before: got %b expected 1", ram_read); end
      @(negedge clk);
      ioctl_upload = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (ram_read !== 1'b0) begin n_bad++; $display("FAIL abort ram_read: got %b expected 0", ram_read); end
      n_cmp++; if (pause_cpu !== 1'b0) begin n_bad++; $display("FAIL abort pause_cpu: got %b expected 0", pause_cpu); end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (ioctl_din !== 8'h00) begin n_bad++; $display("FAIL abort din unchanged: got %02h expected 00", ioctl_din); end
      // A fresh upload must restart the cursor at byte 0.
      upload_start();
      do_rd(0);
      got = ioctl_din;
      exp = sb.pop_front();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL restart rd addr 0: got %02h expected %02h", got, exp); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      @(negedge clk);
      ioctl_addr = 25'd1;
      ioctl_rd   = 1'b1;
      @(negedge clk);
      ioctl_rd   = 1'b0;
      reset      = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (ram_read !== 1'b0) begin n_bad++; $display("FAIL reset_mid ram_read: got %b expected 0", ram_read); end
      n_cmp++; if (pause_cpu !== 1'b0) begin n_bad++; $display("FAIL reset_mid pause_cpu: got %b expected 0", pause_cpu); end
      n_cmp++; if (configured !== 1'b0) begin n_bad++; $display("FAIL reset_mid configured: got %b expected 0", configured); end
      n_cmp++; if (ioctl_din !== 8'h00) begin n_bad++; $display("FAIL reset_mid ioctl_din: got %02h expected 00", ioctl_din); end
      n_cmp++; if (ram_address !== 16'h0000) begin n_bad++; $display("FAIL reset_mid ram_address: got %04h expected 0000", ram_address); end
      @(negedge clk);
      reset        = 1'b0;
      ioctl_upload = 1'b0;
      paused       = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      nreg  = 0;
      bc    = 0;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_upload   = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_rd       = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_addr     = 25'd0;
      ioctl_dout     = 8'd0;
      osd_status     = 1'b0;
      autosave       = 1'b0;
      paused         = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_unconfigured();
      test_config_read();
      test_pause_wait();
      test_addr_mismatch();
      test_wrap();
      test_autosave();
      test_upload_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hiscore_uploader.md
Name: hiscore_uploader

Overview:
- Read-back half of the hiscore path: dumps configured game-RAM regions to the HPS over the ioctl upload channel, byte by byte.
- Owns the config table loaded by download, the CPU pause handshake, the RAM read sequencer and the autosave upload-request pulse.
- Sits between hps_io (ioctl_*) and the game core's shared RAM port, in clk_sys domain.

Parameters:
- HS_ADDRESSWIDTH, 16, game RAM address width.
- CFG_ENTRIES, 4, max config regions (power of 2).
- RAM_LATENCY, 2, clocks from ram_address valid to data_from_ram valid (1..7).
- CFG_INDEX, 3, ioctl_index of config download.
- DATA_INDEX, 4, ioctl_index of hiscore upload.

Ports:
- clk, input, 1, system clock (clk_sys).
- reset, input, 1, synchronous active-high reset.
- ioctl_download, input, 1, download active.
- ioctl_upload, input, 1, upload active.
- ioctl_wr, input, 1, download byte strobe.
- ioctl_rd, input, 1, upload byte request strobe.
- ioctl_index, input, 8, transfer index.
- ioctl_addr, input, 25, byte address.
- ioctl_dout, input, 8, download data.
- ioctl_din, output, 8, upload data.
- ioctl_upload_req, output, 1, one-cycle request for HPS to start an upload.
- osd_status, input, 1, OSD open.
- autosave, input, 1, autosave enable.
- paused, input, 1, CPU is halted.
- pause_cpu, output, 1, request CPU halt.
- ram_address, output, HS_ADDRESSWIDTH, RAM read address.
- data_from_ram, input, 8, RAM read data.
- ram_read, output, 1, read strobe, high for the whole access.
- configured, output, 1, valid table loaded.

Behaviour:
- Reset: all outputs 0, table cleared, entry_count=0, FSM IDLE.
- Config load: ioctl_wr && ioctl_download && ioctl_index==CFG_INDEX. Entry e=ioctl_addr[..:2], accepted only when e<CFG_ENTRIES. Byte0=start[15:8], byte1=start[7:0], byte2=length-1 (1..256 bytes), byte3 ignored. entry_count=max(e)+1.
- configured set on the falling edge of ioctl_download when the index was CFG_INDEX and entry_count>0. Cleared by a new CFG_INDEX download start.
- Autosave: ioctl_upload_req is a one-clock pulse on the osd_status falling edge when autosave && configured && FSM IDLE.
- FSM states: IDLE, PAUSE_WAIT, READY, READ, HOLD.
- IDLE -> PAUSE_WAIT on ioctl_upload rising edge with ioctl_index==DATA_INDEX && configured. This clears cursor (entry=0, offset=0, byte_count=0) and sets pause_cpu=1.
- PAUSE_WAIT -> READY when paused=1. An ioctl_rd arriving here is held pending and serviced on entry to READY.
- READY, on ioctl_rd or pending:
  - ioctl_addr==byte_count and cursor valid: ram_address=start[entry]+offset (wraps mod 2^HS_ADDRESSWIDTH), ram_read=1, go to READ.
  - otherwise (address mismatch or past end): ioctl_din=8'h00 next cycle, cursor unchanged.
- READ: count RAM_LATENCY clocks, then latch data_from_ram into ioctl_din, drop ram_read, advance cursor, go to HOLD.
- Cursor advance: offset==length-1 -> entry++, offset=0; else offset++. byte_count++. Past end when entry==entry_count.
- HOLD -> READY next cycle. ioctl_din is held until the next latch.
- Read latency from ioctl_rd to ioctl_din valid: RAM_LATENCY+1 clocks. hps_io must not strobe faster than RAM_LATENCY+3.
- Upload end (ioctl_upload falls), from any state: abort the read, ram_read=0, pause_cpu=0, -> IDLE.
- A reset mid-upload behaves as full reset; pause_cpu drops in the same cycle.
- Upload with configured=0: ignored, ioctl_din stays 0, pause_cpu stays 0.
- paused dropping during an upload: the FSM stalls in the current state until paused returns.
- ioctl_wr with other indices: ignored.

Test Plan:
- Config load {0xC0,0x00,0x03,x, 0xD1,0x10,0x01,x} then download end -> configured=1, entry_count=2. Upload addr 0..5 returns RAM[C000..C003], RAM[D110..D111], then addr 6 returns 0x00.
- Upload start with paused=0 for 20 clocks, ioctl_rd at addr 0 -> no ram_read until paused=1. Then ioctl_din=RAM[C000] at RAM_LATENCY+1 clocks after paused rises.
- ioctl_rd with ioctl_addr=5 when byte_count=2 -> ioctl_din=0x00, next in-order rd at addr 2 returns RAM[C002].
- Entry start 0xFFFF with length byte 0x01 -> reads 0xFFFF then 0x0000 (wrap).
- autosave=1, configured=1, osd_status 1->0 -> exactly one ioctl_upload_req pulse. With autosave=0 -> none.
- ioctl_upload falls during READ -> next clock ram_read=0, pause_cpu=0, FSM IDLE. reset mid-upload -> all outputs 0 and configured=0.
